alu_mul_sequencer: RTL and testbench

Iterative 32x32->32 multiplier sequencer implementing MULS (low word of the product, sets N/Z) for the small-multiplier core configuration. It is the initiator on the ALU operand/opcode interface: it drives operand A, operand B and the opcode, and consumes the ALU result and flags. It uses only the ALU ADD and SLL operations, one operation per cycle, through shift-add. It sits in the execute stage and owns the ALU while busy_o is high; the execute mux selects its ALU drive whenever alu_req_o = 1.

---
 rtl/alu_mul_sequencer_pkg.sv | 30 +++
 rtl/alu.sv | 34 +++
 rtl/alu_mul_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Opcodes shared by the ALU and the decoder, plus the multiply sequencer state encoding.
// Opcode values are architectural; keep them in sync with the decode tables.
package alu_mul_sequencer_pkg;

   localparam int          DATA_W   = 32;
   localparam int          COUNT_W  = 6;
   localparam logic [5:0]  ITER_MAX = 6'd32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SRL  = 4'b0011,
      ALU_SRA  = 4'b0100,
      ALU_AND  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_XOR  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EVAL,
      ST_ADD,
      ST_SHL,
      ST_DONE
   } seq_state_e;

endpackage

// File: rtl/alu.sv
// Core integer ALU: combinational result plus zero/negative flags, no latency, no flow control.
// Shift amounts use only the low five bits of operand b.
module alu
   import alu_mul_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              neg
);

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << b[4:0];
         ALU_SRL:  result = a >> b[4:0];
         ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'd0, a < b};
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);
   assign neg  = result[DATA_W-1];

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32->32 multiply driving the shared ALU (ADD/SLL only); done_o in cycle 2L+P+3 after accept.
// No backpressure: start_i is taken only in IDLE, anything raised while busy is dropped.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o,
   output logic              n_flag_o,
   output logic              z_flag_o,
   output logic              alu_req_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [3:0]        alu_op_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   input  logic              alu_neg_i
);

   seq_state_e         state_q, state_d;
   logic [DATA_W-1:0]  acc_q, mcand_q, mplier_q;
   logic [COUNT_W-1:0] count_q;
   logic               done_q;
   logic [DATA_W-1:0]  product_q;
   logic               n_q, z_q;
   alu_op_e            alu_op;

   always_comb begin
      state_d = state_q;
      alu_a_o = '0;
      alu_b_o = '0;
      alu_op  = ALU_ADD;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_EVAL;
         end
         ST_EVAL: begin
            if ((count_q == ITER_MAX) || (EARLY_TERM && (mplier_q == '0)))
               state_d = ST_DONE;
            else if (mplier_q[0])
               state_d = ST_ADD;
            else
               state_d = ST_SHL;
         end
         ST_ADD: begin
            alu_a_o = acc_q;
            alu_b_o = mcand_q;
            state_d = ST_SHL;
         end
         ST_SHL: begin
            alu_a_o = mcand_q;
            alu_b_o = 32'd1;
            alu_op  = ALU_SLL;
            state_d = ST_EVAL;
         end
         ST_DONE: begin
            // Pass acc through the ALU so the flags come from the ALU itself.
            alu_a_o = acc_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         product_q <= '0;
         n_q       <= 1'b0;
         z_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_DONE);
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  mcand_q  <= op_a_i;
                  mplier_q <= op_b_i;
                  acc_q    <= '0;
                  count_q  <= '0;
               end
            end
            ST_ADD: acc_q <= alu_result_i;
            ST_SHL: begin
               mcand_q  <= alu_result_i;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + 6'd1;
            end
            ST_DONE: begin
               product_q <= alu_result_i;
               n_q       <= alu_neg_i;
               z_q       <= alu_zero_i;
            end
            default: ;
         endcase
      end
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign alu_req_o = busy_o;
   assign done_o    = done_q;
   assign product_o = product_q;
   assign n_flag_o  = n_q;
   assign z_flag_o  = z_q;
   assign alu_op_o  = alu_op;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for the multiply sequencer: two instances (early-terminate on/off) each driving a real ALU,
// checked cycle by cycle against a transaction-level model plus hand-computed results and latencies.
module tb_alu_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start;
   logic [31:0] op_a, op_b;

   logic [1:0]  busy, done, n_f, z_f, req, alu_z, alu_n;
   logic [31:0] prod [2];
   logic [31:0] alu_a [2];
   logic [31:0] alu_b [2];
   logic [31:0] alu_res [2];
   logic [3:0]  alu_op [2];

   int n_checks = 0;
   int n_fail   = 0;
   bit running  = 1'b0;

   always #5 clk = ~clk;

   alu_mul_sequencer #(.EARLY_TERM(1'b1)) u_seq_et (
      .clk(clk), .rst(rst), .start_i(start[0]), .op_a_i(op_a), .op_b_i(op_b),
      .busy_o(busy[0]), .done_o(done[0]), .product_o(prod[0]), .n_flag_o(n_f[0]), .z_flag_o(z_f[0]),
      .alu_req_o(req[0]), .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_op_o(alu_op[0]),
      .alu_result_i(alu_res[0]), .alu_zero_i(alu_z[0]), .alu_neg_i(alu_n[0]));

   alu u_alu_et (.a(alu_a[0]), .b(alu_b[0]), .op(alu_op[0]),
                 .result(alu_res[0]), .zero(alu_z[0]), .neg(alu_n[0]));

   alu_mul_sequencer #(.EARLY_TERM(1'b0)) u_seq_full (
      .clk(clk), .rst(rst), .start_i(start[1]), .op_a_i(op_a), .op_b_i(op_b),
      .busy_o(busy[1]), .done_o(done[1]), .product_o(prod[1]), .n_flag_o(n_f[1]), .z_flag_o(z_f[1]),
      .alu_req_o(req[1]), .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_op_o(alu_op[1]),
      .alu_result_i(alu_res[1]), .alu_zero_i(alu_z[1]), .alu_neg_i(alu_n[1]));

   alu u_alu_full (.a(alu_a[1]), .b(alu_b[1]), .op(alu_op[1]),
                   .result(alu_res[1]), .zero(alu_z[1]), .neg(alu_n[1]));

   // Cycle of done_o counted from the accept cycle: 2*iterations + ones among them + 3.
   function automatic int latency(input logic [31:0] b, input bit et);
      int iters = 32;
      int ones  = 0;
      if (et) begin
         iters = 0;
         for (int k = 0; k < 32; k++) if (b[k]) iters = k + 1;
      end
      for (int k = 0; k < iters; k++) if (b[k]) ones++;
      return 2 * iters + ones + 3;
   endfunction

   function automatic logic [31:0] mul32(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] full;
      full = {32'd0, a} * {32'd0, b};
      return full[31:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Transaction model: busy window length, done pulse, held result.
   logic        m_busy [2];
   logic        m_done [2];
   int          m_left [2];
   logic [31:0] m_a [2];
   logic [31:0] m_b [2];
   logic [31:0] m_prod [2];
   logic        m_n [2];
   logic        m_z [2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_left[i] <= 0;
            m_a[i] <= '0; m_b[i] <= '0; m_prod[i] <= '0; m_n[i] <= 1'b0; m_z[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
               m_done[i] <= 1'b0;
               if (start[i]) begin
                  m_busy[i] <= 1'b1;
                  m_left[i] <= latency(op_b, i == 0) - 1;
                  m_a[i]    <= op_a;
                  m_b[i]    <= op_b;
               end
            end else if (m_left[i] == 1) begin
               m_busy[i] <= 1'b0;
               m_done[i] <= 1'b1;
               m_prod[i] <= mul32(m_a[i], m_b[i]);
               m_n[i]    <= mul32(m_a[i], m_b[i]) >> 31;
               m_z[i]    <= (mul32(m_a[i], m_b[i]) == 32'd0);
            end else begin
               m_left[i] <= m_left[i] - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (running && !rst) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("busy[%0d]", i), {31'd0, busy[i]}, {31'd0, m_busy[i]});
            check($sformatf("done[%0d]", i), {31'd0, done[i]}, {31'd0, m_done[i]});
            check($sformatf("alu_req[%0d]", i), {31'd0, req[i]}, {31'd0, m_busy[i]});
            if (!m_busy[i]) begin
               check($sformatf("product[%0d]", i), prod[i], m_prod[i]);
               check($sformatf("n_flag[%0d]", i), {31'd0, n_f[i]}, {31'd0, m_n[i]});
               check($sformatf("z_flag[%0d]", i), {31'd0, z_f[i]}, {31'd0, m_z[i]});
               check($sformatf("idle_alu_a[%0d]", i), alu_a[i], 32'd0);
               check($sformatf("idle_alu_b[%0d]", i), alu_b[i], 32'd0);
               check($sformatf("idle_alu_op[%0d]", i), {28'd0, alu_op[i]}, 32'd0);
            end
         end
      end
   end

   // Called at the negedge of the accept cycle; returns at the negedge of cycle 1.
   task automatic launch(input int sel, input logic [31:0] a, input logic [31:0] b);
      op_a       = a;
      op_b       = b;
      start[sel] = 1'b1;
      @(negedge clk);
      start[sel] = 1'b0;
   endtask

   task automatic await_done(input int sel, input string name, input int exp_cyc,
                             input logic [31:0] exp_p, input logic exp_n, input logic exp_z);
      int cyc = 1;
      while (!done[sel] && cyc < 150) begin
         @(negedge clk);
         cyc++;
      end
      check({name, " done cycle"}, cyc, exp_cyc);
      check({name, " product"}, prod[sel], exp_p);
      check({name, " N"}, {31'd0, n_f[sel]}, {31'd0, exp_n});
      check({name, " Z"}, {31'd0, z_f[sel]}, {31'd0, exp_z});
   endtask

   initial begin
      int cyc;
      rst   = 1'b1;
      start = 2'b00;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset busy[%0d]", i), {31'd0, busy[i]}, 32'd0);
         check($sformatf("reset done[%0d]", i), {31'd0, done[i]}, 32'd0);
         check($sformatf("reset product[%0d]", i), prod[i], 32'd0);
      end
      @(negedge clk);
      running = 1'b1;

      check("model latency 3*5", latency(32'd5, 1'b1), 32'd11);
      check("model latency full FFFFFFFF", latency(32'hFFFF_FFFF, 1'b0), 32'd99);

      launch(0, 32'd3, 32'd5);
      await_done(0, "3*5", 11, 32'd15, 1'b0, 1'b0);
      @(negedge clk);
      launch(0, 32'h1234, 32'd0);
      await_done(0, "x*0 early", 3, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      launch(1, 32'h1234, 32'd0);
      await_done(1, "x*0 full", 67, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      launch(1, 32'd3, 32'd5);
      await_done(1, "3*5 full", 69, 32'd15, 1'b0, 1'b0);
      @(negedge clk);
      launch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      await_done(0, "max*max", 99, 32'h0000_0001, 1'b0, 1'b0);
      @(negedge clk);
      launch(0, 32'h0001_0000, 32'h0000_8000);
      await_done(0, "neg wrap", 36, 32'h8000_0000, 1'b1, 1'b0);
      @(negedge clk);
      launch(0, 32'h0001_0000, 32'h0001_0000);
      await_done(0, "zero wrap", 38, 32'h0000_0000, 1'b0, 1'b1);
      @(negedge clk);

      // start_i held high with scrambled operands while busy, then back-to-back accept.
      op_a     = 32'd3;
      op_b     = 32'd5;
      start[0] = 1'b1;
      for (cyc = 1; cyc < 150; cyc++) begin
         @(negedge clk);
         if (done[0]) break;
         op_a = $urandom;
         op_b = $urandom;
      end
      check("held start done cycle", cyc, 32'd11);
      check("held start product", prod[0], 32'd15);
      op_a = 32'd7;
      op_b = 32'd9;
      @(negedge clk);
      start[0] = 1'b0;
      await_done(0, "back-to-back 7*9", 13, 32'd63, 1'b0, 1'b0);
      @(negedge clk);

      // Reset in cycle 5 of a long multiply.
      op_a     = 32'hFFFF_FFFF;
      op_b     = 32'hFFFF_FFFF;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      running = 1'b0;
      rst     = 1'b1;
      #1;
      check("mid reset busy", {31'd0, busy[0]}, 32'd0);
      check("mid reset done", {31'd0, done[0]}, 32'd0);
      check("mid reset alu_req", {31'd0, req[0]}, 32'd0);
      check("mid reset product", prod[0], 32'd0);
      check("mid reset N", {31'd0, n_f[0]}, 32'd0);
      check("mid reset Z", {31'd0, z_f[0]}, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      running = 1'b1;
      launch(0, 32'd7, 32'd6);
      await_done(0, "after reset 7*6", 11, 32'd42, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
